// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: receives a length-prefixed program image and writes it
// word-by-word into RAM, holding the CPU in reset until the image is complete.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_rstrb_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int          CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_LEN, L_DATA, L_WRITE, L_DONE, L_ERROR} ld_state_t;

    logic          rx_meta;
    logic          rxs;
    rx_state_t     rx_state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic          byte_valid;
    logic          frame_err;

    ld_state_t     ld_state;
    logic [31:0]   shreg;
    logic [1:0]    byte_cnt;
    logic [31:0]   word_idx;
    logic [31:0]   word_total;
    logic [31:0]   assembled;

    assign mem_rstrb_o = 1'b0;
    // Bytes arrive LSB-first, so each new byte enters at the top of the shifter.
    assign assembled   = {rx_shift, shreg[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (!rxs) rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rxs, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt    <= '0;
                        byte_valid <= rxs;
                        frame_err  <= !rxs;
                        rx_state   <= RX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state    <= L_LEN;
            shreg       <= '0;
            byte_cnt    <= '0;
            word_idx    <= '0;
            word_total  <= '0;
            mem_wmask_o <= '0;
            mem_addr_o  <= BASE_ADDR;
            mem_wdata_o <= '0;
            cpu_rst_o   <= 1'b1;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            mem_wmask_o <= '0;
            case (ld_state)
                L_LEN: begin
                    if (frame_err) begin
                        ld_state <= L_ERROR;
                        error_o  <= 1'b1;
                    end else if (byte_valid) begin
                        shreg    <= assembled;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            if (assembled == '0) begin
                                ld_state  <= L_DONE;
                                cpu_rst_o <= 1'b0;
                                done_o    <= 1'b1;
                            end else if (assembled > MAX_W) begin
                                ld_state <= L_ERROR;
                                error_o  <= 1'b1;
                            end else begin
                                word_total <= assembled;
                                ld_state   <= L_DATA;
                            end
                        end
                    end
                end
                L_DATA: begin
                    if (frame_err) begin
                        ld_state <= L_ERROR;
                        error_o  <= 1'b1;
                    end else if (byte_valid) begin
                        shreg    <= assembled;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            // Outputs are registered, so the strobe lands in the WRITE cycle.
                            mem_wmask_o <= 4'hF;
                            mem_addr_o  <= BASE_ADDR + (word_idx << 2);
                            mem_wdata_o <= assembled;
                            ld_state    <= L_WRITE;
                        end
                    end
                end
                L_WRITE: begin
                    word_idx <= word_idx + 32'd1;
                    if (word_idx + 32'd1 == word_total) begin
                        ld_state  <= L_DONE;
                        cpu_rst_o <= 1'b0;
                        done_o    <= 1'b1;
                    end else begin
                        ld_state <= L_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table-driven directed loads, hand
// sequences for reset/glitch corners, and random images against a queue model.
module tb_uart_boot_loader;

    localparam int CPB  = 4;
    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_i = 1'b1;
    logic [31:0] mem_addr_o;
    logic        mem_rstrb_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        error_o;

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_i(rx_i),
        .mem_addr_o(mem_addr_o),
        .mem_rstrb_o(mem_rstrb_o),
        .mem_wmask_o(mem_wmask_o),
        .mem_wdata_o(mem_wdata_o),
        .cpu_rst_o(cpu_rst_o),
        .done_o(done_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Observed write transactions, captured mid-cycle.
    logic [31:0] act_addr[$];
    logic [31:0] act_data[$];
    int          cyc = 0;
    int          last_wr_cyc = -1;
    int          done_rise_cyc = -1;
    logic        done_q = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_wmask_o != 4'h0) begin
                chk("wmask_full", 32'(mem_wmask_o), 32'hF);
                act_addr.push_back(mem_addr_o);
                act_data.push_back(mem_wdata_o);
                last_wr_cyc = cyc;
            end
            if (done_o && !done_q) done_rise_cyc = cyc;
        end
        done_q = done_o;
    end

    task automatic clear_obs();
        act_addr.delete();
        act_data.delete();
        last_wr_cyc = -1;
        done_rise_cyc = -1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop_ok;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    logic [7:0] bq[$];
    bit         sq[$];

    task automatic send_stream();
        for (int i = 0; i < bq.size(); i++) send_byte(bq[i], sq[i]);
        repeat (20) @(negedge clk);
    endtask

    // Reference: bytes after the first bad stop bit are never delivered; the
    // first 4 delivered bytes are N, each following group of 4 is one word.
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_err;

    task automatic model();
        int          e;
        int          m;
        int          avail;
        int          nw;
        logic [31:0] n;
        e = -1;
        for (int i = 0; i < sq.size(); i++)
            if (!sq[i] && e < 0) e = i;
        m = (e < 0) ? bq.size() : e;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err = 0;
        if (m < 4) begin
            exp_err = (e >= 0);
        end else begin
            n = {bq[3], bq[2], bq[1], bq[0]};
            if (n == 0) exp_done = 1;
            else if (n > MAXW) exp_err = 1;
            else begin
                avail = (m - 4) / 4;
                nw = (avail < int'(n)) ? avail : int'(n);
                for (int w = 0; w < nw; w++) begin
                    exp_addr.push_back(32'(4 * w));
                    exp_data.push_back({bq[4+4*w+3], bq[4+4*w+2], bq[4+4*w+1], bq[4+4*w]});
                end
                if (nw == int'(n)) exp_done = 1;
                else if (e >= 0) exp_err = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        model();
        chk({tag, "_nwrites"}, 32'(act_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            chk({tag, "_addr"}, act_addr[i], exp_addr[i]);
            chk({tag, "_data"}, act_data[i], exp_data[i]);
        end
        chk({tag, "_done"}, 32'(done_o), 32'(exp_done));
        chk({tag, "_error"}, 32'(error_o), 32'(exp_err));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst_o), 32'(!exp_done));
        chk({tag, "_rstrb"}, 32'(mem_rstrb_o), 32'h0);
        if (exp_done && exp_addr.size() > 0)
            chk({tag, "_done_timing"}, 32'(done_rise_cyc), 32'(last_wr_cyc + 1));
    endtask

    typedef struct {
        string       name;
        int          nbytes;
        logic [95:0] stream;
        int          bad_idx;
        int          exp_writes;
        logic [31:0] exp_addr0;
        logic [31:0] exp_data0;
        bit          exp_done;
        bit          exp_error;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{"img2",    12, 96'h02000000_13000000_6F000000, -1, 2, 32'h0, 32'h0000_0013, 1'b1, 1'b0};
        tbl[1] = '{"len0",     6, 96'h00000000_AA55,              -1, 0, 32'h0, 32'h0,         1'b1, 1'b0};
        tbl[2] = '{"len17",   12, 96'h11000000_01000000_EFBEADDE, -1, 0, 32'h0, 32'h0,         1'b0, 1'b1};
        tbl[3] = '{"badstop",  5, 96'h01000000_A5,                 4, 0, 32'h0, 32'h0,         1'b0, 1'b1};

        @(negedge clk);
        do_reset(3);
        for (int i = 0; i < 100; i++) begin
            chk("idle_cpu_rst", 32'(cpu_rst_o), 32'h1);
            chk("idle_flags", {30'h0, done_o, error_o}, 32'h0);
            chk("idle_wmask_addr", {mem_wmask_o, mem_addr_o[27:0]}, 32'h0);
            @(negedge clk);
        end

        for (int v = 0; v < 4; v++) begin
            do_reset(3);
            bq.delete();
            sq.delete();
            for (int i = 0; i < tbl[v].nbytes; i++) begin
                bq.push_back(tbl[v].stream[(tbl[v].nbytes - 1 - i) * 8 +: 8]);
                sq.push_back(i != tbl[v].bad_idx);
            end
            send_stream();
            chk({tbl[v].name, "_tbl_nwrites"}, 32'(act_addr.size()), 32'(tbl[v].exp_writes));
            if (tbl[v].exp_writes > 0 && act_addr.size() > 0) begin
                chk({tbl[v].name, "_tbl_addr0"}, act_addr[0], tbl[v].exp_addr0);
                chk({tbl[v].name, "_tbl_data0"}, act_data[0], tbl[v].exp_data0);
            end
            chk({tbl[v].name, "_tbl_done"}, 32'(done_o), 32'(tbl[v].exp_done));
            chk({tbl[v].name, "_tbl_error"}, 32'(error_o), 32'(tbl[v].exp_error));
            check_model(tbl[v].name);
        end

        // One-cycle low glitch while idle must not be taken as a start bit.
        do_reset(2);
        rx_i = 1'b0;
        @(negedge clk);
        rx_i = 1'b1;
        repeat (20) @(negedge clk);
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        sq = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_stream();
        chk("glitch_nwrites", 32'(act_addr.size()), 32'd1);
        if (act_data.size() > 0) chk("glitch_data", act_data[0], 32'h1234_5678);
        check_model("glitch");

        // Reset mid-image, right after the first write, then a fresh load.
        do_reset(2);
        bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        sq = '{1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < bq.size(); i++) send_byte(bq[i], sq[i]);
        for (int t = 0; t < 2000 && act_addr.size() == 0; t++) @(negedge clk);
        chk("midrst_first_write", 32'(act_addr.size()), 32'd1);
        do_reset(1);
        chk("midrst_addr", mem_addr_o, 32'h0);
        chk("midrst_wdata", mem_wdata_o, 32'h0);
        chk("midrst_wmask", 32'(mem_wmask_o), 32'h0);
        chk("midrst_flags", {29'h0, cpu_rst_o, done_o, error_o}, 32'h4);
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        sq = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_stream();
        chk("reload_nwrites", 32'(act_addr.size()), 32'd1);
        if (act_addr.size() > 0) begin
            chk("reload_addr", act_addr[0], 32'h0);
            chk("reload_data", act_data[0], 32'hDEAD_BEEF);
        end
        chk("reload_done", 32'(done_o), 32'h1);

        for (int r = 0; r < 12; r++) begin
            int          sel;
            logic [31:0] n;
            int          body;
            do_reset(2);
            bq.delete();
            sq.delete();
            sel = $urandom_range(0, 9);
            if (sel == 0) n = 0;
            else if (sel == 1) n = 32'(MAXW + 1 + $urandom_range(0, 100));
            else n = 32'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) bq.push_back(n[i*8 +: 8]);
            body = (n > MAXW) ? 4 : 4 * int'(n);
            for (int i = 0; i < body + $urandom_range(0, 2); i++) bq.push_back(8'($urandom));
            for (int i = 0; i < bq.size(); i++) sq.push_back(1'b1);
            if ($urandom_range(0, 3) == 0) sq[$urandom_range(0, bq.size() - 1)] = 1'b0;
            send_stream();
            check_model($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream of the SoC memory bus: receives a program image over a serial RX line (8N1) and writes it word-by-word into RAM.
- Holds the processor in reset until the image is fully loaded.
- Drives the same memory-port signal set the CPU drives. The SoC bus selects the loader while cpu_rst_o=1 and the CPU otherwise.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (≥4).
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word (word-aligned).
- MAX_WORDS, 4096, largest accepted word count (RAM size / 4).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous to clk, active-high.
- rx_i  input  1  asynchronous serial input, idle high.
- mem_addr_o  output  32  write byte address.
- mem_rstrb_o  output  1  read strobe; constant 0.
- mem_wmask_o  output  4  byte write mask; 4'hF for exactly one cycle per word, else 0.
- mem_wdata_o  output  32  write data.
- cpu_rst_o  output  1  processor reset request.
- done_o  output  1  load complete; sticky.
- error_o  output  1  load aborted; sticky.

Behaviour:
- Reset values:
  - cpu_rst_o=1, done_o=0, error_o=0.
  - mem_wmask_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, mem_rstrb_o=0.
  - RX synchroniser flops=1.
  - All counters=0.
- Reset taken in any state, including mid-byte or mid-image, returns to these values. The next load starts again at BASE_ADDR.
- rx_i passes through a 2-flop synchroniser; all RX logic uses the synchronised value rxs.
- RX FSM:
  - RX_IDLE -> RX_START when rxs=0.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then resample. If rxs=1 it is a glitch: return to RX_IDLE with no byte. Otherwise -> RX_DATA.
  - RX_DATA: sample 8 bits, each CLKS_PER_BIT cycles apart, LSB first.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - If the stop bit =1: byte_valid pulses for 1 cycle on the next cycle.
    - If the stop bit =0: framing error -> loader enters ERROR. No byte is delivered.
  - Then -> RX_IDLE.
- Loader FSM:
  - LEN: collect 4 bytes little-endian into the count N.
    - N=0 -> DONE.
    - N>MAX_WORDS -> ERROR.
    - Otherwise -> DATA.
  - DATA: collect 4 bytes little-endian into a word. On the 4th byte -> WRITE.
  - WRITE (1 cycle):
    - Drive mem_wmask_o=4'hF, mem_addr_o=BASE_ADDR+4*k (k = word index from 0, 32-bit wrap), mem_wdata_o=word.
    - If k+1==N -> DONE, else -> DATA.
    - The next byte cannot arrive before WRITE completes, because bytes are ≥10*CLKS_PER_BIT cycles apart.
  - DONE:
    - From the first DONE cycle: cpu_rst_o=0, done_o=1.
    - Further RX bytes and framing errors are ignored. Leave only via rst.
  - ERROR: error_o=1 and cpu_rst_o stays 1. No further writes. RX is ignored. Leave only via rst.
- mem_addr_o and mem_wdata_o hold their last values outside WRITE. mem_wmask_o is 0 in every state other than WRITE.
- A byte_valid pulse and a state change never coincide destructively: a framing error during LEN or DATA goes to ERROR; the same error during DONE or ERROR has no effect.

Test Plan (CLKS_PER_BIT=4, BASE_ADDR=0, MAX_WORDS=16):
1. Assert rst 3 cycles with rx_i=1, then release.
   -> cpu_rst_o=1, done_o=0, error_o=0, mem_wmask_o=0, mem_addr_o=0 throughout 100 idle cycles.
2. Send bytes 02 00 00 00 13 00 00 00 6F 00 00 00.
   -> One-cycle write addr 0x0 data 0x00000013 wmask F.
   -> One-cycle write addr 0x4 data 0x0000006F.
   -> Next cycle cpu_rst_o=0 and done_o=1, both held.
   -> No other cycle with wmask≠0.
3. Send 00 00 00 00.
   -> DONE one cycle after the 4th byte_valid; zero writes.
   -> Subsequent bytes AA 55 cause no writes.
4. Send 11 00 00 00 (N=17).
   -> error_o=1, cpu_rst_o stays 1, no writes.
   -> A following valid image is ignored until rst.
5. Send 01 00 00 00, then a byte with stop bit driven 0.
   -> error_o=1, no write.
   -> Separately, pulse rx_i low for 1 cycle while idle -> no byte accepted; a following full image loads correctly.
6. Send a 2-word image and assert rst for 1 cycle after the first write.
   -> All outputs return to reset values.
   -> A fresh 1-word image (01 00 00 00 EF BE AD DE) writes 0xDEADBEEF to addr 0x0, then done_o=1.
